// File: rtl/vc_read_scheduler_pkg.sv
// Shared NoC types and defaults for the VC read scheduler slice.
// Optional error reporting in the scheduler is enabled with VC_SCHED_ERR_EN.
package noc_params;

  typedef enum logic [1:0] {
    HEAD     = 2'd0,
    BODY     = 2'd1,
    TAIL     = 2'd2,
    HEADTAIL = 2'd3
  } flit_type_t;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } sched_state_t;

  localparam int VC_NUM    = 4;
  localparam int VC_SIZE   = 8;
  localparam int VC_SIZE_W = $clog2(VC_NUM);

endpackage

// File: rtl/vc_read_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: the first requester at or after ptr wins.
// N must be a power of two so the index wraps for free.
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] ptr,
  output logic [N-1:0]         grant
);

  localparam int W = $clog2(N);

  logic [W-1:0] idx;
  logic         found;

  always_comb begin
    // NOTE: every combinationally assigned variable gets a default first so no latch is inferred.
    grant = '0;
    found = 1'b0;
    idx   = '0;
    for (int i = 0; i < N; i++) begin
      idx = ptr + W'(i);
      if (!found && req[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/vc_read_scheduler.sv
// Shares one output link among VC_NUM buffers with credit flow control and wormhole locking.
// Define VC_SCHED_ERR_EN to add a sticky protocol/credit error flag on error_o.
module vc_read_scheduler #(
  parameter int VC_NUM      = noc_params::VC_NUM,
  parameter int BUFFER_SIZE = noc_params::VC_SIZE
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [VC_NUM-1:0]         is_empty_i,
  input  logic [2*VC_NUM-1:0]       flit_type_i,
  input  logic [VC_NUM-1:0]         credit_i,
  output logic [VC_NUM-1:0]         read_o,
  output logic                      valid_o,
  output logic [$clog2(VC_NUM)-1:0] vc_sel_o
`ifdef VC_SCHED_ERR_EN
  ,
  output logic                      error_o
`endif
);

  import noc_params::flit_type_t, noc_params::sched_state_t;
  import noc_params::HEAD, noc_params::BODY, noc_params::TAIL, noc_params::HEADTAIL;
  import noc_params::IDLE, noc_params::LOCKED;

  localparam int VW = $clog2(VC_NUM);
  localparam int CW = $clog2(BUFFER_SIZE + 1);

  sched_state_t    fsm_q, fsm_d;
  logic [VW-1:0]   lock_vc_q, lock_vc_d;
  logic [VW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [CW-1:0]   credit_q [VC_NUM];
  logic [CW-1:0]   credit_d [VC_NUM];

  logic [VC_NUM-1:0] eligible, req, grant_raw, grant, full;
  logic [VW-1:0]     gnt_idx;
  logic              gnt_valid;
  flit_type_t        gnt_type;

  always_comb begin
    eligible = '0;
    full     = '0;
    for (int v = 0; v < VC_NUM; v++) begin
      eligible[v] = !is_empty_i[v] && (credit_q[v] != '0);
      full[v]     = (credit_q[v] == CW'(BUFFER_SIZE));
    end
    req = eligible;
    if (fsm_q == LOCKED) req = eligible & (VC_NUM'(1) << lock_vc_q);
  end

  rr_arbiter #(.N(VC_NUM)) u_arb (
    .req   (req),
    .ptr   (rr_ptr_q),
    .grant (grant_raw)
  );

  // Outputs must read as zero during reset even though inputs may look eligible.
  assign grant     = grant_raw & {VC_NUM{rst_n}};
  assign gnt_valid = |grant;

  always_comb begin
    gnt_idx = '0;
    for (int v = 0; v < VC_NUM; v++) begin
      if (grant[v]) gnt_idx = VW'(v);
    end
    gnt_type = flit_type_t'(flit_type_i[2*gnt_idx +: 2]);
  end

  assign read_o   = grant;
  assign valid_o  = gnt_valid;
  assign vc_sel_o = gnt_idx;

  always_comb begin
    fsm_d     = fsm_q;
    lock_vc_d = lock_vc_q;
    rr_ptr_d  = rr_ptr_q;
    if (gnt_valid) begin
      case (fsm_q)
        IDLE: begin
          if (gnt_type == HEAD) begin
            fsm_d     = LOCKED;
            lock_vc_d = gnt_idx;
          end else begin
            rr_ptr_d = gnt_idx + VW'(1);
          end
        end
        LOCKED: begin
          if (gnt_type == TAIL) begin
            fsm_d    = IDLE;
            rr_ptr_d = lock_vc_q + VW'(1);
          end
        end
        default: fsm_d = IDLE;
      endcase
    end
  end

  // A simultaneous grant and credit return cancel; a return on a full counter is dropped.
  always_comb begin
    for (int v = 0; v < VC_NUM; v++) begin
      credit_d[v] = credit_q[v];
      if (grant[v] && !credit_i[v])
        credit_d[v] = credit_q[v] - CW'(1);
      else if (!grant[v] && credit_i[v] && !full[v])
        credit_d[v] = credit_q[v] + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments only; the credit array is real state and is reset too.
    if (!rst_n) begin
      fsm_q     <= IDLE;
      lock_vc_q <= '0;
      rr_ptr_q  <= '0;
      for (int v = 0; v < VC_NUM; v++) credit_q[v] <= CW'(BUFFER_SIZE);
    end else begin
      fsm_q     <= fsm_d;
      lock_vc_q <= lock_vc_d;
      rr_ptr_q  <= rr_ptr_d;
      for (int v = 0; v < VC_NUM; v++) credit_q[v] <= credit_d[v];
    end
  end

`ifdef VC_SCHED_ERR_EN
  logic err_q, err_d;
  logic proto_err, sat_err;

  always_comb begin
    proto_err = 1'b0;
    if (gnt_valid) begin
      if (fsm_q == IDLE)
        proto_err = (gnt_type == BODY) || (gnt_type == TAIL);
      else
        proto_err = (gnt_type == HEAD) || (gnt_type == HEADTAIL);
    end
    sat_err = |(credit_i & ~grant & full);
    err_d   = err_q | proto_err | sat_err;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_q <= 1'b0;
    else        err_q <= err_d;
  end

  assign error_o = err_q;
`endif

endmodule

// File: tb/tb_vc_read_scheduler.sv
// Self-checking bench for vc_read_scheduler: directed table, corner sequences, random vs model.
module tb_vc_read_scheduler;
  import noc_params::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] is_empty_i;
  logic [7:0] flit_type_i;
  logic [3:0] credit_i;
  logic [3:0] read_o;
  logic       valid_o;
  logic [1:0] vc_sel_o;
`ifdef VC_SCHED_ERR_EN
  logic       error_o;
`endif

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  vc_read_scheduler #(.VC_NUM(4), .BUFFER_SIZE(8)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .is_empty_i  (is_empty_i),
    .flit_type_i (flit_type_i),
    .credit_i    (credit_i),
    .read_o      (read_o),
    .valid_o     (valid_o),
    .vc_sel_o    (vc_sel_o)
`ifdef VC_SCHED_ERR_EN
    ,
    .error_o     (error_o)
`endif
  );

  // Reference model: link ownership, round-robin start and free downstream slots per VC.
  bit m_locked;
  int m_lock;
  int m_ptr;
  int m_cred [4];

  function automatic void model_reset();
    m_locked = 1'b0;
    m_lock   = 0;
    m_ptr    = 0;
    for (int v = 0; v < 4; v++) m_cred[v] = 8;
  endfunction

  function automatic int model_grant(input logic [3:0] e);
    if (m_locked) return (!e[m_lock] && m_cred[m_lock] > 0) ? m_lock : -1;
    for (int i = 0; i < 4; i++) begin
      int v = (m_ptr + i) % 4;
      if (!e[v] && m_cred[v] > 0) return v;
    end
    return -1;
  endfunction

  function automatic void model_update(input logic [3:0] e, input logic [7:0] t, input logic [3:0] c);
    int g = model_grant(e);
    if (g >= 0) begin
      int ty = (t >> (2 * g)) & 3;
      if (!m_locked) begin
        if (ty == int'(HEAD)) begin
          m_locked = 1'b1;
          m_lock   = g;
        end else begin
          m_ptr = (g + 1) % 4;
        end
      end else if (ty == int'(TAIL)) begin
        m_locked = 1'b0;
        m_ptr    = (m_lock + 1) % 4;
      end
    end
    for (int v = 0; v < 4; v++) begin
      if (g == v && !c[v])                   m_cred[v] = m_cred[v] - 1;
      else if (g != v && c[v] && m_cred[v] < 8) m_cred[v] = m_cred[v] + 1;
    end
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Called at a falling edge: drive, check the zero-latency outputs, then cross one rising edge.
  task automatic run_vec(input logic [3:0] e, input logic [7:0] t, input logic [3:0] c,
                         input logic [3:0] exp_rd, input logic [1:0] exp_sel, input string name);
    is_empty_i  = e;
    flit_type_i = t;
    credit_i    = c;
    #1;
    check({name, ".read"},  32'(read_o),   32'(exp_rd));
    check({name, ".valid"}, 32'(valid_o),  32'(exp_rd != 4'b0));
    check({name, ".sel"},   32'(vc_sel_o), 32'(exp_sel));
    model_update(e, t, c);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  typedef struct {
    logic [3:0] e;
    logic [7:0] t;
    logic [3:0] c;
    logic [3:0] rd;
    logic [1:0] sel;
  } vec_t;

  vec_t tbl [13];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Type bytes: VC3[7:6] VC2[5:4] VC1[3:2] VC0[1:0]; HEAD=0 BODY=1 TAIL=2 HEADTAIL=3.
    tbl[0]  = '{4'b1011, 8'hFF, 4'b0000, 4'b0100, 2'd2};
    tbl[1]  = '{4'b0000, 8'hFF, 4'b0000, 4'b1000, 2'd3};
    tbl[2]  = '{4'b0000, 8'hFF, 4'b0000, 4'b0001, 2'd0};
    tbl[3]  = '{4'b0000, 8'hFF, 4'b0000, 4'b0010, 2'd1};
    tbl[4]  = '{4'b0000, 8'hFF, 4'b0000, 4'b0100, 2'd2};
    tbl[5]  = '{4'b0000, 8'hFF, 4'b0000, 4'b1000, 2'd3};
    tbl[6]  = '{4'b1111, 8'hFF, 4'b0000, 4'b0000, 2'd0};
    tbl[7]  = '{4'b0001, 8'hF3, 4'b0000, 4'b0010, 2'd1};
    tbl[8]  = '{4'b0000, 8'hF7, 4'b0000, 4'b0010, 2'd1};
    tbl[9]  = '{4'b0010, 8'hFF, 4'b0000, 4'b0000, 2'd0};
    tbl[10] = '{4'b0000, 8'hFB, 4'b0000, 4'b0010, 2'd1};
    tbl[11] = '{4'b0000, 8'hFF, 4'b0000, 4'b0100, 2'd2};
    tbl[12] = '{4'b0111, 8'hFF, 4'b1000, 4'b1000, 2'd3};

    rst_n       = 1'b0;
    is_empty_i  = 4'b0000;
    flit_type_i = 8'hFF;
    credit_i    = 4'b0000;
    model_reset();
    #1;
    check("reset.read",  32'(read_o),   32'd0);
    check("reset.valid", 32'(valid_o),  32'd0);
    check("reset.sel",   32'(vc_sel_o), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 13; i++)
      run_vec(tbl[i].e, tbl[i].t, tbl[i].c, tbl[i].rd, tbl[i].sel, $sformatf("tbl%0d", i));

    // Reset while locked on VC1 mid-packet.
    do_reset();
    run_vec(4'b1101, 8'h00, 4'b0000, 4'b0010, 2'd1, "mid.head");
    run_vec(4'b0000, 8'h04, 4'b0000, 4'b0010, 2'd1, "mid.body");
    rst_n = 1'b0;
    model_reset();
    #1;
    check("mid.rst_read",  32'(read_o),   32'd0);
    check("mid.rst_valid", 32'(valid_o),  32'd0);
    check("mid.rst_sel",   32'(vc_sel_o), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_vec(4'b0000, 8'hFF, 4'b0000, 4'b0001, 2'd0, "mid.after");

    // Credit exhaustion and saturation on VC0.
    do_reset();
    run_vec(4'b1111, 8'hFF, 4'b0001, 4'b0000, 2'd0, "cred.sat");
`ifdef VC_SCHED_ERR_EN
    check("cred.err", 32'(error_o), 32'd1);
`endif
    for (int i = 0; i < 8; i++)
      run_vec(4'b1110, 8'hFF, 4'b0000, 4'b0001, 2'd0, $sformatf("cred.g%0d", i));
    run_vec(4'b1110, 8'hFF, 4'b0000, 4'b0000, 2'd0, "cred.empty");
    run_vec(4'b1110, 8'hFF, 4'b0001, 4'b0000, 2'd0, "cred.return");
    run_vec(4'b1110, 8'hFF, 4'b0000, 4'b0001, 2'd0, "cred.regrant");
    run_vec(4'b1110, 8'hFF, 4'b0000, 4'b0000, 2'd0, "cred.again");

    // Randomised traffic against the model.
    do_reset();
    for (int i = 0; i < 400; i++) begin
      logic [3:0] e, c, rd;
      logic [7:0] t;
      logic [1:0] sel;
      int g;
      e = 4'($urandom_range(0, 15)) & 4'($urandom_range(0, 15));
      t = 8'($urandom);
      c = 4'($urandom_range(0, 15)) & 4'($urandom_range(0, 15)) & 4'($urandom_range(0, 15));
      g = model_grant(e);
      rd  = (g >= 0) ? 4'(1 << g) : 4'b0000;
      sel = (g >= 0) ? 2'(g) : 2'd0;
      run_vec(e, t, c, rd, sel, $sformatf("rnd%0d", i));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
